// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and the control decoder.
package fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    ERROR = 2'b11
  } fetchState_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_MISALIGN = 2'b10
  } errCode_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // Instructions are 32-bit, so a fetch address must have its two low bits clear.
  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return (lowBits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting for an instruction-memory ack.
// expired_o flags the enabled cycle that brings the count up to LIMIT.
module fetch_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise count up and saturate at LIMIT.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != W'(LIMIT))) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV64 fetch stage: owns the PC, fetches one 32-bit word at a time over a
// req/ack handshake, holds it for decode and advances on consumption.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              ACK_TIMEOUT = 16
) (
  input  logic            clkInput,
  input  logic            resetInput,
  output logic            imemReqOutput,
  output logic [XLEN-1:0] imemAddrOutput,
  input  logic            imemAckInput,
  input  logic [31:0]     imemDataInput,
  input  logic            stallInput,
  input  logic            branchTakenInput,
  input  logic [XLEN-1:0] branchTargetInput,
  output logic            instrValidOutput,
  output logic [31:0]     instrOutput,
  output logic [6:0]      opcodeOutput,
  output logic [XLEN-1:0] pcOutput,
  output logic            errorOutput,
  output logic [1:0]      errorCodeOutput
);

  fetchState_t     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  errCode_t        errCode_q, errCode_d;

  logic            inFetch;
  logic            ackExpired;
  logic [XLEN-1:0] candidatePc;

  assign inFetch     = (state_q == FETCH);
  assign candidatePc = branchTakenInput ? branchTargetInput : (pc_q + XLEN'(4));

  fetch_timeout_counter #(
    .LIMIT(ACK_TIMEOUT)
  ) u_timeout (
    .clk_i    (clkInput),
    .reset_i  (resetInput),
    .clear_i  (inFetch && imemAckInput),
    .enable_i (inFetch && !imemAckInput),
    .expired_o(ackExpired)
  );

  // Next-state logic: handshake with memory, then wait for decode to consume.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    errCode_d = errCode_q;
    case (state_q)
      START: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imemAckInput) begin
          instr_d = imemDataInput;
          state_d = HOLD;
        end else if (ackExpired) begin
          errCode_d = ERR_TIMEOUT;
          state_d   = ERROR;
        end
      end
      HOLD: begin
        if (!stallInput) begin
          if (!isWordAligned(candidatePc[1:0])) begin
            errCode_d = ERR_MISALIGN;
            state_d   = ERROR;
          end else begin
            pc_d    = candidatePc;
            state_d = FETCH;
          end
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = START;
      end
    endcase
  end

  // State, PC, instruction and error registers with synchronous reset.
  always_ff @(posedge clkInput) begin
    if (resetInput) begin
      state_q   <= START;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      errCode_q <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      errCode_q <= errCode_d;
    end
  end

  assign imemReqOutput    = inFetch;
  assign imemAddrOutput   = pc_q;
  assign instrValidOutput = (state_q == HOLD);
  assign instrOutput      = instr_q;
  assign opcodeOutput     = instr_q[6:0];
  assign pcOutput         = pc_q;
  assign errorOutput      = (state_q == ERROR);
  assign errorCodeOutput  = errCode_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit: one instance at the
// default reset PC, one at the top of the address space to exercise wrap.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN    = 64;
  localparam int          TIMEOUT = 16;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } expFetch_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, ack, stall, brTaken;
  logic [31:0] data;
  logic [63:0] brTarget;
  logic        req, valid, err;
  logic [63:0] addr, pcOut;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [1:0]  errCode;

  logic        wReset, wAck, wStall, wBrTaken;
  logic [31:0] wData;
  logic [63:0] wBrTarget;
  logic        wReq, wValid, wErr;
  logic [63:0] wAddr, wPc;
  logic [31:0] wInstr;
  logic [6:0]  wOpcode;
  logic [1:0]  wErrCode;

  int checks   = 0;
  int failures = 0;

  logic [63:0] expAddrQ[$];
  expFetch_t   expInstrQ[$];

  instruction_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(64'h0), .ACK_TIMEOUT(TIMEOUT)
  ) dut (
    .clkInput(clock), .resetInput(reset),
    .imemReqOutput(req), .imemAddrOutput(addr),
    .imemAckInput(ack), .imemDataInput(data),
    .stallInput(stall), .branchTakenInput(brTaken), .branchTargetInput(brTarget),
    .instrValidOutput(valid), .instrOutput(instr), .opcodeOutput(opcode),
    .pcOutput(pcOut), .errorOutput(err), .errorCodeOutput(errCode)
  );

  instruction_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(WRAP_PC), .ACK_TIMEOUT(TIMEOUT)
  ) dutWrap (
    .clkInput(clock), .resetInput(wReset),
    .imemReqOutput(wReq), .imemAddrOutput(wAddr),
    .imemAckInput(wAck), .imemDataInput(wData),
    .stallInput(wStall), .branchTakenInput(wBrTaken), .branchTargetInput(wBrTarget),
    .instrValidOutput(wValid), .instrOutput(wInstr), .opcodeOutput(wOpcode),
    .pcOutput(wPc), .errorOutput(wErr), .errorCodeOutput(wErrCode)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic s,
                               input logic b, input logic [31:0] d,
                               input logic [63:0] t);
    reset    = r;
    ack      = a;
    stall    = s;
    brTaken  = b;
    data     = d;
    brTarget = t;
  endtask

  // Compare the outstanding request against the next expected address.
  task automatic expectFetchRequest(output logic [63:0] expAddr);
    expAddr = expAddrQ.pop_front();
    checkOutput("reqHigh", req, 64'd1);
    checkOutput("reqAddr", addr, expAddr);
  endtask

  // Act as instruction memory: ack after 'delay' idle cycles, then check HOLD.
  task automatic serviceFetch(input int delay, input logic [31:0] word);
    logic [63:0] a;
    expFetch_t   e;
    expectFetchRequest(a);
    for (int i = 0; i < delay; i++) step();
    checkOutput("reqHeld", req, 64'd1);
    checkOutput("addrHeld", addr, a);
    ack  = 1'b1;
    data = word;
    e.pc    = a;
    e.instr = word;
    expInstrQ.push_back(e);
    step();
    ack  = 1'b0;
    data = '0;
    e = expInstrQ.pop_front();
    checkOutput("validAfterAck", valid, 64'd1);
    checkOutput("instrHeld", instr, e.instr);
    checkOutput("pcHeld", pcOut, e.pc);
    checkOutput("opcodeField", opcode, e.instr[6:0]);
    checkOutput("reqDropInHold", req, 64'd0);
  endtask

  // Downstream consumes the held instruction; the next request address is queued.
  task automatic consume(input logic taken, input logic [63:0] target,
                         input logic [63:0] expNext);
    stall    = 1'b0;
    brTaken  = taken;
    brTarget = target;
    expAddrQ.push_back(expNext);
    step();
    brTaken  = 1'b0;
    brTarget = '0;
    checkOutput("validDropOnConsume", valid, 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] a;
    wReset = 1'b1; wAck = 1'b0; wStall = 1'b0; wBrTaken = 1'b0;
    wData = '0; wBrTarget = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    step();
    step();
    checkOutput("rstReq", req, 64'd0);
    checkOutput("rstValid", valid, 64'd0);
    checkOutput("rstErr", err, 64'd0);
    checkOutput("rstCode", errCode, 64'd0);
    checkOutput("rstInstr", instr, 64'd0);
    checkOutput("rstPc", pcOut, 64'd0);

    // Release reset; request appears one cycle after START.
    reset = 1'b0;
    expAddrQ.push_back(64'h0);
    step();
    serviceFetch(2, 32'h00A30333);
    checkOutput("opcodeRtype", opcode, OP_RTYPE);

    // Stall for five cycles: everything frozen, branch inputs ignored.
    stall = 1'b1; brTaken = 1'b1; brTarget = 64'h200;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stallValid", valid, 64'd1);
      checkOutput("stallReq", req, 64'd0);
      checkOutput("stallInstr", instr, 64'h00A30333);
      checkOutput("stallPc", pcOut, 64'h0);
    end

    // Sequential advance, then a taken BEQ to 0x100.
    consume(1'b0, 64'h0, 64'h4);
    serviceFetch(0, 32'h00208463);
    checkOutput("opcodeBeq", opcode, OP_BEQ);
    consume(1'b1, 64'h100, 64'h100);
    serviceFetch(0, 32'h0000B183);
    checkOutput("opcodeLd", opcode, OP_LD);

    // Ack on the last allowed cycle still wins over the timeout.
    consume(1'b0, 64'h0, 64'h104);
    serviceFetch(TIMEOUT - 1, 32'h0030B023);
    checkOutput("opcodeSd", opcode, OP_SD);
    checkOutput("noErrAfterLateAck", err, 64'd0);

    // No ack at all: error after the sixteenth waiting cycle.
    consume(1'b0, 64'h0, 64'h108);
    expectFetchRequest(a);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    checkOutput("stillFetching", req, 64'd1);
    checkOutput("noErrYet", err, 64'd0);
    step();
    checkOutput("timeoutErr", err, 64'd1);
    checkOutput("timeoutCode", errCode, {62'd0, ERR_TIMEOUT});
    checkOutput("timeoutReq", req, 64'd0);
    checkOutput("timeoutValid", valid, 64'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    checkOutput("errSticky", err, 64'd1);
    checkOutput("errIgnoresAck", valid, 64'd0);

    // Reset clears the error and refetches from the reset PC.
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("postRstErr", err, 64'd0);
    checkOutput("postRstCode", errCode, 64'd0);
    checkOutput("postRstPc", pcOut, 64'h0);
    expAddrQ.push_back(64'h0);
    step();
    serviceFetch(0, 32'h002081B3);

    // Misaligned branch target: error code 10, PC unchanged, no more requests.
    stall = 1'b0; brTaken = 1'b1; brTarget = 64'h102;
    step();
    brTaken = 1'b0; brTarget = '0;
    checkOutput("misErr", err, 64'd1);
    checkOutput("misCode", errCode, {62'd0, ERR_MISALIGN});
    checkOutput("misPc", pcOut, 64'h0);
    checkOutput("misValid", valid, 64'd0);
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1;
      step();
      checkOutput("misReqLow", req, 64'd0);
    end
    ack = 1'b0;
    checkOutput("misCodeHeld", errCode, {62'd0, ERR_MISALIGN});

    // Wrap instance: PC+4 from the top of the address space wraps to zero.
    wReset = 1'b0;
    checkOutput("wrapRstPc", wPc, WRAP_PC);
    step();
    checkOutput("wrapReq", wReq, 64'd1);
    checkOutput("wrapAddr", wAddr, WRAP_PC);
    wAck = 1'b1; wData = 32'h00000013;
    step();
    wAck = 1'b0; wData = '0;
    checkOutput("wrapValid", wValid, 64'd1);
    checkOutput("wrapInstr", wInstr, 64'h00000013);
    step();
    checkOutput("wrapNextReq", wReq, 64'd1);
    checkOutput("wrapNextAddr", wAddr, 64'h0);

    // Reset mid-fetch; an ack arriving during START is dropped.
    wReset = 1'b1;
    step();
    checkOutput("wrapStartReq", wReq, 64'd0);
    wReset = 1'b0; wAck = 1'b1; wData = 32'hDEADBEEF;
    step();
    wAck = 1'b0; wData = '0;
    checkOutput("lateAckValid", wValid, 64'd0);
    checkOutput("lateAckInstr", wInstr, 64'h0);
    checkOutput("refetchAddr", wAddr, WRAP_PC);
    checkOutput("refetchReq", wReq, 64'd1);
    step();
    wAck = 1'b1; wData = 32'h00A30333;
    step();
    wAck = 1'b0; wData = '0;
    checkOutput("refetchInstr", wInstr, 64'h00A30333);
    checkOutput("refetchPc", wPc, WRAP_PC);
    checkOutput("refetchOpcode", wOpcode, OP_RTYPE);
    checkOutput("wrapNoErr", {wErr, wErrCode}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
